// File: rtl/mux_4x1_rr_arbiter_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
interface mux_4x1_rr_arbiter_if;
   logic [3:0] req;
   logic [3:0] grant;
   logic [1:0] sel;
   logic       busy;

   // Requester side: raises requests, observes grant/select.
   modport master (
      output req,
      input  grant,
      input  sel,
      input  busy
   );

   // Arbiter side.
   modport slave (
      input  req,
      output grant,
      output sel,
      output busy
   );
endinterface

// File: rtl/mux_4x1_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4x1 mux, with a bounded
// grant length of HOLD_MAX cycles and same-edge re-arbitration on release.
module mux_4x1_rr_arbiter #(
   parameter int unsigned HOLD_MAX = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   mux_4x1_rr_arbiter_if.slave   arb
);

   localparam int unsigned N_REQ   = 4;
   localparam int unsigned SEL_W   = 2;
   localparam int unsigned CNT_W   = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t             state, state_nxt;
   logic [N_REQ-1:0]   grant, grant_nxt;
   logic [SEL_W-1:0]   sel, sel_nxt;
   logic               busy, busy_nxt;
   logic [SEL_W-1:0]   ptr, ptr_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;

   // Scan r starting at index p; returns {found, winner index}.
   function automatic logic [SEL_W:0] arbitrate(input logic [N_REQ-1:0] r,
                                                input logic [SEL_W-1:0] p);
      logic             found;
      logic [SEL_W-1:0] idx;
      logic [SEL_W-1:0] win;
      found = 1'b0;
      win   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = p + SEL_W'(i);
         if (!found && r[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      return {found, win};
   endfunction

   // State and registered outputs; synchronous reset has priority.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         grant <= '0;
         sel   <= '0;
         busy  <= 1'b0;
         ptr   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
         sel   <= sel_nxt;
         busy  <= busy_nxt;
         ptr   <= ptr_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state: grant on request, hold until drop or hold limit, then rotate.
   always_comb begin
      logic [SEL_W:0]   res;
      logic [SEL_W-1:0] new_ptr;
      logic             release_c;

      state_nxt = state;
      grant_nxt = grant;
      sel_nxt   = sel;
      busy_nxt  = busy;
      ptr_nxt   = ptr;
      cnt_nxt   = cnt;
      res       = '0;
      new_ptr   = ptr;
      release_c = 1'b0;

      unique case (state)
         IDLE: begin
            res = arbitrate(arb.req, ptr);
            if (res[SEL_W]) begin
               state_nxt = GRANT;
               grant_nxt = N_REQ'(1) << res[SEL_W-1:0];
               sel_nxt   = res[SEL_W-1:0];
               busy_nxt  = 1'b1;
               cnt_nxt   = CNT_W'(1);
            end
         end
         GRANT: begin
            release_c = !arb.req[sel] || (cnt == CNT_W'(HOLD_MAX));
            if (!release_c) begin
               cnt_nxt = cnt + CNT_W'(1);
            end else begin
               // Released requester drops to lowest priority.
               new_ptr = sel + SEL_W'(1);
               ptr_nxt = new_ptr;
               res     = arbitrate(arb.req, new_ptr);
               if (res[SEL_W]) begin
                  grant_nxt = N_REQ'(1) << res[SEL_W-1:0];
                  sel_nxt   = res[SEL_W-1:0];
                  cnt_nxt   = CNT_W'(1);
               end else begin
                  // sel is kept so the mux output stays stable while idle.
                  state_nxt = IDLE;
                  grant_nxt = '0;
                  busy_nxt  = 1'b0;
                  cnt_nxt   = '0;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign arb.grant = grant;
   assign arb.sel   = sel;
   assign arb.busy  = busy;

endmodule
